bcd_down_timer: RTL and testbench
=================================

# bcd_down_timer

Two-digit BCD countdown timer with load, start, pause and an expiry pulse. Digits drive two seven-segment outputs for the board display. It counts down once per divided tick, stops at 00 and raises a one-cycle `done` pulse. It is the down-counting companion to the team's free-running BCD up-counter, intended for lab timers and timeout indicators.

## Interface
Parameters:
- `TICK_DIV`, 50_000_000: `clock` cycles per count step; legal range 2..2^26.
- `SEG_INVERT`, 0: 1 inverts all segment outputs (active-low displays).

Ports:
- `clock`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  load `load_tens`/`load_ones`, go to IDLE.
- `load_tens`  in  4  tens digit to load.
- `load_ones`  in  4  ones digit to load.
- `start`  in  1  begin/resume counting.
- `pause`  in  1  suspend counting.
- `tens`  out  4  current tens digit, BCD.
- `ones`  out  4  current ones digit, BCD.
- `display1`  out  7  segments for `ones`, gfedcba order.
- `display2`  out  7  segments for `tens`, gfedcba order.
- `running`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse on expiry.

## Operation
- States: IDLE, RUN, PAUSED, EXPIRED.
- Input priority per cycle: `reset` > `load` > `start`/`pause`.
- `load`, any state: digits take the loaded values, divider is cleared, state goes to IDLE. A digit above 9 is clamped to 9. `done` is not asserted.
- IDLE + `start`: if the value is nonzero, go to RUN with the divider cleared. If the value is 00, go to EXPIRED and pulse `done`.
- RUN + `pause`: go to PAUSED; the divider value is held. `start` in RUN has no effect, so `pause` wins.
- PAUSED + `start`: go to RUN; the divider resumes from its held value.
- RUN, tick: decrement the value.
  - If `ones` != 0: `ones` - 1.
  - Else: `ones` = 9 and `tens` - 1.
- RUN, tick when the value is 01: the value becomes 00, state goes to EXPIRED, and `done` pulses.
- EXPIRED: digits hold at 00. `start` and `pause` are ignored; only `load` or `reset` leaves this state.
- Wrap below 00 never occurs. Digits never leave the range 0..9.
- Segment map for 0..9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex). Any other code gives 00 (blank). XOR the map with 7F when `SEG_INVERT` = 1.

## Timing
- Reset values:
  - `tens` = 0, `ones` = 0, `running` = 0, `done` = 0, state IDLE, divider 0.
  - `display1` = `display2` = 3F (40 when `SEG_INVERT` = 1).
- Divider counts 0..`TICK_DIV`-1 only while in RUN. Tick is asserted when the divider equals `TICK_DIV`-1; the divider then returns to 0.
- The first decrement takes effect `TICK_DIV` clocks after the `start` edge; subsequent decrements occur every `TICK_DIV` clocks.
- Digits, `running` and `done` are registered and update on the tick edge.
  - `done` is high in exactly the first cycle of EXPIRED, coincident with the digits reading 00.
- Segment outputs are combinational from the digit registers: zero added latency, glitch-free relative to the digit registers.
- `running` = 1 exactly in RUN cycles.
- `reset` or `load` asserted in the same cycle as a tick: the tick is discarded.

## Structure
- Package `bcd_timer_pkg`:
  - state encoding (IDLE/RUN/PAUSED/EXPIRED);
  - the 10-entry segment constant table and the blank code;
  - the BCD max digit constant (9).
- Sub-module `tick_divider`:
  - parameter `TICK_DIV`;
  - inputs `clock`, `reset`, `clear`, `enable`;
  - output `tick`.
- Segment lookup is a function in the package, instantiated twice.
- FSM and BCD datapath live in `bcd_down_timer`.

## Test plan
All scenarios use `TICK_DIV` = 4.
1. Assert `reset` 2 cycles → `tens` = 0, `ones` = 0, both displays 3F, `running` = 0, `done` = 0.
2. Load 1,0, then `start` → 4 cycles later 0,9. At cycle 40 the value is 0,0, `done` is high for exactly 1 cycle, and `running` drops in that same cycle.
3. Load 0,5, `start`, `pause` at cycle 6 (value 0,4, divider at 2), hold 10 cycles → value stays 0,4. Then `start` → 0,3 two cycles after the resume edge.
4. Load C,F (hex) → digits read 9,9, displays 6F/6F. Then `start` → 9,8 after 4 cycles.
5. Load 0,0, then `start` → next cycle state EXPIRED and `done` = 1 for 1 cycle. A further `start` produces no `done`.
6. Load 3,2, run to 3,0, then assert `load` with 0,7 on a tick cycle → digits 0,7, state IDLE, `running` = 0, `done` never asserts.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the two-digit BCD countdown timer:
// FSM state encoding, digit limits and the seven-segment lookup.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StPaused  = 2'd2,
    StExpired = 2'd3
  } timer_state_e;

  localparam logic [3:0] BcdMax   = 4'd9;
  localparam logic [3:0] BcdZero  = 4'd0;
  localparam logic [6:0] SegBlank = 7'h00;
  localparam logic [6:0] SegMask  = 7'h7F;

  // Segment patterns for digits 0..9, gfedcba order, active-high.
  localparam logic [6:0] SegTable [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] digit, input logic invert);
    logic [6:0] seg;
    seg = SegBlank;
    case (digit)
      4'd0:    seg = SegTable[0];
      4'd1:    seg = SegTable[1];
      4'd2:    seg = SegTable[2];
      4'd3:    seg = SegTable[3];
      4'd4:    seg = SegTable[4];
      4'd5:    seg = SegTable[5];
      4'd6:    seg = SegTable[6];
      4'd7:    seg = SegTable[7];
      4'd8:    seg = SegTable[8];
      4'd9:    seg = SegTable[9];
      default: seg = SegBlank;
    endcase
    return invert ? (seg ^ SegMask) : seg;
  endfunction

  function automatic logic [3:0] clamp_digit(input logic [3:0] digit);
    return (digit > BcdMax) ? BcdMax : digit;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running step divider: counts 0..TICK_DIV-1 while enabled and pulses
// tick on the terminal count. Holds its value while disabled.
module tick_divider #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// Two-digit BCD countdown timer with load/start/pause, a one-cycle expiry
// pulse and combinational seven-segment decode of both digits.
module bcd_down_timer
  import bcd_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned SEG_INVERT = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] display1,
  output logic [6:0] display2,
  output logic       running,
  output logic       done
);

  timer_state_e state_q, state_d;
  logic [3:0]   tens_q, tens_d;
  logic [3:0]   ones_q, ones_d;
  logic         running_q, running_d;
  logic         done_q, done_d;

  logic div_clear;
  logic div_enable;
  logic tick;
  logic value_zero;
  logic value_one;

  assign value_zero = (tens_q == BcdZero) && (ones_q == BcdZero);
  assign value_one  = (tens_q == BcdZero) && (ones_q == 4'd1);

  // Pause freezes the divider in the same cycle it is seen, so a pending
  // tick is deferred rather than lost.
  assign div_enable = (state_q == StRun) && !pause && !load;
  assign div_clear  = load || ((state_q == StIdle) && start);

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clock  (clock),
    .reset  (reset),
    .clear  (div_clear),
    .enable (div_enable),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    done_d  = 1'b0;

    if (load) begin
      tens_d  = clamp_digit(load_tens);
      ones_d  = clamp_digit(load_ones);
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (value_zero) begin
              state_d = StExpired;
              done_d  = 1'b1;
            end else begin
              state_d = StRun;
            end
          end
        end
        StRun: begin
          if (pause) begin
            state_d = StPaused;
          end else if (tick) begin
            if (ones_q != BcdZero) begin
              ones_d = ones_q - 4'd1;
            end else begin
              ones_d = BcdMax;
              tens_d = tens_q - 4'd1;
            end
            if (value_one) begin
              state_d = StExpired;
              done_d  = 1'b1;
            end
          end
        end
        StPaused: begin
          if (start) begin
            state_d = StRun;
          end
        end
        StExpired: begin
          state_d = StExpired;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    running_d = (state_d == StRun);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      tens_q    <= BcdZero;
      ones_q    <= BcdZero;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign tens     = tens_q;
  assign ones     = ones_q;
  assign running  = running_q;
  assign done     = done_q;
  assign display1 = seg_encode(ones_q, SEG_INVERT != 0);
  assign display2 = seg_encode(tens_q, SEG_INVERT != 0);

endmodule

// File: tb/tb_bcd_down_timer.sv
// Scoreboard bench: stimulus pushes the reference model's expected outputs per
// clock edge; a monitor pops and compares them just after each edge.
module tb_bcd_down_timer;

  localparam int unsigned TD = 4;

  logic       clock = 1'b0;
  logic       reset, load, start, pause;
  logic [3:0] load_tens, load_ones;
  logic [3:0] tens, ones, tens_i, ones_i;
  logic [6:0] display1, display2, display1_i, display2_i;
  logic       running, done, running_i, done_i;

  always #5 clock = ~clock;

  bcd_down_timer #(.TICK_DIV(TD), .SEG_INVERT(0)) u_dut (
    .clock(clock), .reset(reset), .load(load), .load_tens(load_tens),
    .load_ones(load_ones), .start(start), .pause(pause), .tens(tens), .ones(ones),
    .display1(display1), .display2(display2), .running(running), .done(done)
  );

  bcd_down_timer #(.TICK_DIV(TD), .SEG_INVERT(1)) u_dut_inv (
    .clock(clock), .reset(reset), .load(load), .load_tens(load_tens),
    .load_ones(load_ones), .start(start), .pause(pause), .tens(tens_i), .ones(ones_i),
    .display1(display1_i), .display2(display2_i), .running(running_i), .done(done_i)
  );

  typedef struct {
    int tens;
    int ones;
    int d1;
    int d2;
    int running;
    int done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   seg_ref [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  // Reference model: value held as a plain integer 0..99.
  int m_val   = 0;
  int m_state = 0;  // 0 idle, 1 run, 2 paused, 3 expired
  int m_div   = 0;

  function automatic int seg_of(input int d);
    return (d >= 0 && d <= 9) ? seg_ref[d] : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit rst, input bit ld, input int lt, input int lo,
                     input bit st, input bit pa);
    exp_t e;
    int   done_m;
    logic [3:0] lt4, lo4;
    lt4 = lt[3:0];
    lo4 = lo[3:0];
    reset = rst; load = ld; load_tens = lt4; load_ones = lo4; start = st; pause = pa;
    done_m = 0;
    if (rst) begin
      m_val = 0; m_state = 0; m_div = 0;
    end else if (ld) begin
      m_val = ((lt4 > 9) ? 9 : int'(lt4)) * 10 + ((lo4 > 9) ? 9 : int'(lo4));
      m_state = 0; m_div = 0;
    end else begin
      case (m_state)
        0: if (st) begin
          if (m_val == 0) begin m_state = 3; done_m = 1; end
          else begin m_state = 1; m_div = 0; end
        end
        1: if (pa) m_state = 2;
           else if (m_div == TD - 1) begin
             m_div = 0;
             m_val = m_val - 1;
             if (m_val == 0) begin m_state = 3; done_m = 1; end
           end else m_div = m_div + 1;
        2: if (st) m_state = 1;
        default: ;
      endcase
    end
    e.tens = m_val / 10;
    e.ones = m_val % 10;
    e.d1 = seg_of(e.ones);
    e.d2 = seg_of(e.tens);
    e.running = (m_state == 1) ? 1 : 0;
    e.done = done_m;
    sb.push_back(e);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("tens", int'(tens), e.tens);
        check("ones", int'(ones), e.ones);
        check("display1", int'(display1), e.d1);
        check("display2", int'(display2), e.d2);
        check("running", int'(running), e.running);
        check("done", int'(done), e.done);
        check("display1_inv", int'(display1_i), e.d1 ^ 'h7F);
        check("display2_inv", int'(display2_i), e.d2 ^ 'h7F);
        check("done_inv", int'(done_i), e.done);
      end
    end
  end

  initial begin : stimulus
    int lt, lo;
    // Reset
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    // Full countdown from 10
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(45);
    // Pause mid-step, hold, resume
    cyc(0, 1, 0, 5, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(5);
    cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, (i % 2) == 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(6);
    // Clamp of out-of-range digits
    cyc(0, 1, 12, 15, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(9);
    // Start at zero, then a further start
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(2);
    cyc(0, 0, 0, 0, 1, 1);
    idle(2);
    // Load on a tick cycle
    cyc(0, 1, 3, 2, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(11);
    cyc(0, 1, 0, 7, 0, 0);
    idle(6);
    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      lt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1));
      lo = int'($urandom_range(0, 15));
      cyc($urandom_range(0, 127) == 0, $urandom_range(0, 23) == 0, lt, lo,
          $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
    end
    repeat (3) @(negedge clock);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
